// File: rtl/hamming_encoder_pkg.sv
// Shared SECDED definitions: width codes, per-width sizes and the syndrome-to-position
// table also used by the decoder's error-fix stage.
package hamming_encoder_pkg;

    typedef enum logic [1:0] {
        CW_SMALL  = 2'b00,
        CW_MEDIUM = 2'b01,
        CW_LARGE  = 2'b10
    } cw_width_e;

    localparam int unsigned R_SMALL     = 3;
    localparam int unsigned R_MEDIUM    = 4;
    localparam int unsigned R_LARGE     = 5;
    localparam int unsigned DATA_SMALL  = 4;
    localparam int unsigned DATA_MEDIUM = 11;
    localparam int unsigned DATA_LARGE  = 26;
    localparam int unsigned MAX_R       = R_LARGE;
    localparam int unsigned MAX_DATA    = DATA_LARGE;

    // Syndrome of data bit dk: the non-powers-of-two in ascending order.
    localparam logic [4:0] SYNDROME_TABLE [MAX_DATA] = '{
        5'd3,  5'd5,  5'd6,  5'd7,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13,
        5'd14, 5'd15, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
        5'd24, 5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31
    };

    function automatic cw_width_e norm_width(input logic [1:0] w);
        case (w)
            2'b00:   return CW_SMALL;
            2'b01:   return CW_MEDIUM;
            default: return CW_LARGE;
        endcase
    endfunction

    function automatic logic [MAX_DATA-1:0] data_mask(input cw_width_e w);
        case (w)
            CW_SMALL:  return 26'h000_000F;
            CW_MEDIUM: return 26'h000_07FF;
            default:   return '1;
        endcase
    endfunction

    function automatic logic [31:0] width_mask(input cw_width_e w);
        case (w)
            CW_SMALL:  return 32'h0000_00FF;
            CW_MEDIUM: return 32'h0000_FFFF;
            default:   return '1;
        endcase
    endfunction

endpackage

// File: rtl/hamming_encoder_parity_gen.sv
// Combinational parity generator: p[j] is the XOR of every data bit whose syndrome has bit j set.
module hamming_parity_gen
    import hamming_encoder_pkg::*;
(
    input  logic [25:0] data_i,
    input  logic [1:0]  width_i,
    output logic [4:0]  p_o
);

    logic [25:0] data_m;

    always_comb begin
        data_m = data_i & data_mask(norm_width(width_i));
        p_o    = '0;
        for (int unsigned i = 0; i < MAX_DATA; i++) begin
            for (int unsigned j = 0; j < MAX_R; j++) begin
                if (SYNDROME_TABLE[i][j]) begin
                    p_o[j] = p_o[j] ^ data_m[i];
                end
            end
        end
    end

endmodule

// File: rtl/hamming_encoder.sv
// SECDED encoder with a two-stage valid/ready pipeline and an optional noise mask on the output.
module hamming_encoder
    import hamming_encoder_pkg::*;
#(
    parameter int AMBA_WORD  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            cw_width,
    input  logic [AMBA_WORD-1:0]  noise,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AMBA_WORD-1:0]  cw_out,
    output logic [1:0]            out_width
);

    cw_width_e            in_width;
    logic [25:0]          in_data_m;
    logic [4:0]           in_p;
    logic                 unused_data;

    logic                 s1_valid_q, s1_valid_d;
    logic [25:0]          s1_data_q, s1_data_d;
    logic [4:0]           s1_p_q, s1_p_d;
    cw_width_e            s1_width_q, s1_width_d;
    logic [AMBA_WORD-1:0] s1_noise_q, s1_noise_d;

    logic                 out_valid_q, out_valid_d;
    logic [AMBA_WORD-1:0] cw_q, cw_d;
    cw_width_e            out_width_q, out_width_d;

    logic                 s1_adv, s2_adv;
    logic                 overall;
    logic [AMBA_WORD-1:0] clean_cw;

    assign unused_data = ^data_in[DATA_WIDTH-1:26];
    assign in_width    = norm_width(cw_width);
    assign in_data_m   = data_in[25:0] & data_mask(in_width);

    hamming_parity_gen u_parity (
        .data_i  (in_data_m),
        .width_i (in_width),
        .p_o     (in_p)
    );

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_p_d     = s1_p_q;
        s1_width_d = s1_width_q;
        s1_noise_d = s1_noise_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_data_d  = in_data_m;
                s1_p_d     = in_p;
                s1_width_d = in_width;
                s1_noise_d = noise & width_mask(in_width);
            end
        end
    end

    // Stored data is already masked and unused parity bits are zero, so one XOR covers every width.
    always_comb begin
        overall  = ^{s1_data_q, s1_p_q};
        clean_cw = '0;
        case (s1_width_q)
            CW_SMALL:  clean_cw[7:0]  = {s1_data_q[3:0], overall, s1_p_q[2:0]};
            CW_MEDIUM: clean_cw[15:0] = {s1_data_q[10:0], overall, s1_p_q[3:0]};
            default:   clean_cw[31:0] = {s1_data_q[25:0], overall, s1_p_q[4:0]};
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        cw_d        = cw_q;
        out_width_d = out_width_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                cw_d        = clean_cw ^ s1_noise_q;
                out_width_d = s1_width_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_p_q      <= '0;
            s1_width_q  <= CW_SMALL;
            s1_noise_q  <= '0;
            out_valid_q <= 1'b0;
            cw_q        <= '0;
            out_width_q <= CW_SMALL;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            s1_p_q      <= s1_p_d;
            s1_width_q  <= s1_width_d;
            s1_noise_q  <= s1_noise_d;
            out_valid_q <= out_valid_d;
            cw_q        <= cw_d;
            out_width_q <= out_width_d;
        end
    end

    assign out_valid = out_valid_q;
    assign cw_out    = cw_q;
    assign out_width = out_width_q;

endmodule
